// File: rtl/mem_loader.sv
// mem_loader: feeder and memory for the max-finder processor.
//
// A stream of DATA_W-bit words arrives over a valid/ready handshake and is
// written into a DEPTH-entry register file. The register file also serves
// the processor's combinational read port. The processor is held in reset
// while words are loaded (LOAD). It is released for exactly RUN_CYCLES
// cycles (RUN). It is then held in reset again, with `done` raised, until
// software pulses `clear` (DONE).
//
// Optional feature: define MEM_LOADER_AUTOCLEAR_EN to zero every memory
// entry on each DONE->LOAD transition. When it is undefined, the memory
// contents persist across runs and only `reset` zeroes them.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   wr_valid   in   an input word is present
//   wr_data    in   input word
//   wr_ready   out  block can accept a word (high only in LOAD)
//   go         in   in LOAD, start a run before the memory is full
//   clear      in   in DONE, return to LOAD
//   rd_addr    in   read address (the processor's addr)
//   rd_data    out  mem[rd_addr] (the processor's din)
//   proc_rst   out  active-high processor reset (low only in RUN)
//   busy       out  high in RUN
//   done       out  high in DONE
//   fill       out  words written since the last entry into LOAD
//   dbg_state  out  current FSM state encoding (0 LOAD, 1 RUN, 2 DONE)
//
// Handshake: a word transfers on a rising edge where wr_valid and wr_ready
// are both high. wr_valid may assert regardless of wr_ready. wr_ready does
// not depend on wr_valid.
module mem_loader #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int RUN_CYCLES = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              go,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              proc_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   fill,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (RUN_CYCLES > 2) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [ADDR_W:0]   FILL_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  // Reset release chain. Stage 0 is set on the first edge after `reset`
  // rises, so the first write is taken on the second edge. The go/clear
  // controls wait for stage 1, so they act only after a full two-flop
  // release.
  logic [1:0] rel_q;
  logic       wr_fire;
  logic       go_ok;
  logic       clear_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rel_q <= 2'b00;
    end else begin
      rel_q <= {rel_q[0], 1'b1};
    end
  end

  // Outputs are decoded from the state register only, so they are glitch-free.
  assign wr_ready  = (state_q == S_LOAD);
  assign proc_rst  = (state_q != S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign fill      = fill_q;
  assign dbg_state = state_q;

  // The read is combinational on the registered array. A same-cycle write
  // to the same address therefore shows the old value until the next edge.
  assign rd_data = mem_q[rd_addr];

  assign wr_fire  = wr_valid & wr_ready & rel_q[0];
  assign go_ok    = go & rel_q[1];
  assign clear_ok = clear & rel_q[1];

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;

    case (state_q)
      S_LOAD: begin
        // A write in the same cycle as `go` is still performed.
        if (wr_fire) begin
          mem_d[wptr_q] = wr_data;
          wptr_d        = wptr_q + 1'b1;
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
          end
        end
        if ((wr_fire && (fill_d == FILL_FULL)) || go_ok) begin
          state_d = S_RUN;
          cnt_d   = CNT_LOAD;
        end
      end

      S_RUN: begin
        // The counter is loaded with RUN_CYCLES-1 on entry. Leaving on the
        // edge where it reads 0 keeps proc_rst low for RUN_CYCLES cycles.
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        if (clear_ok) begin
          state_d = S_LOAD;
          wptr_d  = '0;
          fill_d  = '0;
`ifdef MEM_LOADER_AUTOCLEAR_EN
          for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
          end
`else
          mem_d = mem_q;
`endif
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      wptr_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader with default parameters
// (DEPTH 16, DATA_W 4, RUN_CYCLES 18).
module tb_mem_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       wr_valid;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic       go;
  logic       clear;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic       proc_rst;
  logic       busy;
  logic       done;
  logic [4:0] fill;
  logic [1:0] dbg_state;

  mem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .go        (go),
    .clear     (clear),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .proc_rst  (proc_rst),
    .busy      (busy),
    .done      (done),
    .fill      (fill),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] model_mem [16];
  logic [3:0] exp_q [$];
  logic [3:0] load_words [16] = '{4'h3, 4'h7, 4'h1, 4'hF, 4'h0, 4'h2, 4'h9, 4'h4,
                                  4'h8, 4'h6, 4'h5, 4'hC, 4'hA, 4'hB, 4'hD, 4'hE};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are driven, and outputs sampled, 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
`ifdef MEM_LOADER_AUTOCLEAR_EN
    for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
`endif
  endtask

  // Counts the cycles from the current point until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  int         cyc;
  logic [3:0] max_seen;
  logic [3:0] max_exp;

  initial begin
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 4'h0;
    go       = 1'b0;
    clear    = 1'b0;
    rd_addr  = 4'h5;
    for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;

    // ---- reset state ----
    tick(); tick(); tick();
    check_eq("rst_wr_ready", wr_ready, 1);
    check_eq("rst_proc_rst", proc_rst, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_fill", fill, 0);
    check_eq("rst_rd_data", rd_data, 0);

    // ---- full load; the first edge after release must not take a word ----
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = load_words[0];
    tick();
    check_eq("edge1_no_accept", fill, 0);
    for (int i = 0; i < 16; i++) begin
      wr_data = load_words[i];
      tick();
      model_mem[i] = load_words[i];
      exp_q.push_back(load_words[i]);
      if (i == 7) begin
        check_eq("load_fill_mid", fill, 8);
        check_eq("load_busy_mid", busy, 0);
      end
    end
    check_eq("full_busy", busy, 1);
    check_eq("full_proc_rst", proc_rst, 0);
    check_eq("full_fill", fill, 16);

    // ---- backpressure in RUN (wr_valid=1, F), plus clear ignored in RUN ----
    wr_data = 4'hF;
    cyc = 0;
    while (!done && cyc < 100) begin
      clear = (cyc == 4);
      if (cyc == 2) check_eq("run_wr_ready", wr_ready, 0);
      tick();
      cyc++;
    end
    clear    = 1'b0;
    wr_valid = 1'b0;
    check_eq("run_length", cyc, 18);
    check_eq("done_flag", done, 1);
    check_eq("done_proc_rst", proc_rst, 1);
    check_eq("done_fill", fill, 16);

    // ---- read back memory, find max ----
    max_seen = 4'h0;
    max_exp  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (load_words[i] > max_exp) max_exp = load_words[i];
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check_eq($sformatf("mem_%0d", i), rd_data, exp_q.pop_front());
      if (rd_data > max_seen) max_seen = rd_data;
    end
    check_eq("max_value", max_seen, max_exp);

    // ---- clear ----
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    check_eq("clr_done", done, 0);
    check_eq("clr_wr_ready", wr_ready, 1);
    check_eq("clr_fill", fill, 0);

    // ---- early go: 5, 9, then 2 together with go ----
    wr_valid = 1'b1;
    wr_data = 4'h5; tick(); model_mem[0] = 4'h5;
    wr_data = 4'h9; tick(); model_mem[1] = 4'h9;
    wr_data = 4'h2; go = 1'b1; tick(); model_mem[2] = 4'h2;
    go       = 1'b0;
    wr_valid = 1'b0;
    check_eq("early_fill", fill, 3);
    check_eq("early_busy", busy, 1);
    rd_addr = 4'd2; #1;
    check_eq("early_mem2", rd_data, 2);
    rd_addr = 4'd3; #1;
    check_eq("early_mem3_kept", rd_data, model_mem[3]);
    wait_done(cyc);
    check_eq("early_run_length", cyc, 18);
    clear = 1'b1; tick(); clear = 1'b0;
    model_clear();

    // ---- read during write at address 0 ----
    rd_addr  = 4'd0;
    wr_valid = 1'b1;
    wr_data  = 4'hA;
    #1;
    check_eq("rdw_old", rd_data, model_mem[0]);
    tick();
    wr_valid = 1'b0;
    model_mem[0] = 4'hA;
    check_eq("rdw_new", rd_data, 4'hA);

    // ---- async reset mid-RUN ----
    go = 1'b1; tick(); go = 1'b0;
    tick(); tick();
    check_eq("pre_rst_busy", busy, 1);
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst_proc_rst", proc_rst, 1);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_rd_data", rd_data, 0);
    for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
    tick();
    reset = 1'b1;
    tick(); tick();
    check_eq("rel_wr_ready", wr_ready, 1);
    check_eq("rel_fill", fill, 0);

    // ---- go with fill = 0 ----
    go = 1'b1; tick(); go = 1'b0;
    check_eq("go0_busy", busy, 1);
    check_eq("go0_fill", fill, 0);
    wait_done(cyc);
    check_eq("go0_run_length", cyc, 18);
    check_eq("go0_done", done, 1);

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Feeder and memory for the max-finder processor. Accepts a stream of 4-bit words over a valid/ready handshake and writes them into a 16-entry register file. Serves the processor's address-driven read port (`addr` in, `din` out). Holds the processor in reset while loading, releases it for a fixed run window, then flags completion until software clears it.

## Interface
- `DEPTH`, 16: number of memory entries; a power of two.
- `ADDR_W`, 4: address width, equal to log2(`DEPTH`).
- `DATA_W`, 4: word width.
- `RUN_CYCLES`, 18: number of cycles the processor is held out of reset per run; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  an input word is present.
- `wr_data`  in  `DATA_W`  input word.
- `wr_ready`  out  1  the block can accept a word.
- `go`  in  1  in LOAD, start a run before the memory is full.
- `clear`  in  1  in DONE, return to LOAD.
- `rd_addr`  in  `ADDR_W`  read address; connects to the processor's `addr`.
- `rd_data`  out  `DATA_W`  read data, equal to `mem[rd_addr]`; connects to the processor's `din`.
- `proc_rst`  out  1  active-high reset for the processor.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `fill`  out  `ADDR_W+1`  number of words written since the last entry into LOAD.

## Operation
- **States:** LOAD, RUN, DONE. Reset enters LOAD.
- **Reset values:** all memory entries 0, `wptr` 0, `fill` 0, run counter 0, `proc_rst` 1, `busy` 0, `done` 0, `wr_ready` 1. While reset is held, `rd_data` is 0.

**LOAD**
- `wr_ready` = 1.
- A handshake (`wr_valid & wr_ready`) writes `mem[wptr] <= wr_data`, then increments `wptr` and `fill`.
- The handshake that makes `fill` reach `DEPTH` moves the block to RUN.
- `go` = 1 also moves the block to RUN. If a handshake occurs in the same cycle, the write is performed first.
- With `go`, entries that were not written keep their previous contents.
- `go` with `fill` = 0 is legal.

**RUN**
- `wr_ready` = 0; `proc_rst` = 0; `busy` = 1.
- The run counter loads `RUN_CYCLES-1` on entry and decrements every cycle.
- When the counter reaches 0, the block moves to DONE.
- `go`, `clear` and `wr_valid` are ignored.

**DONE**
- `done` = 1; `proc_rst` = 1, freezing the processor's `max` output for reading.
- `wr_ready` = 0.
- `clear` = 1 moves the block to LOAD and resets `wptr` and `fill` to 0.

**Read port**
- Combinational: `rd_data = mem[rd_addr]` in every state.
- A write and a read to the same address in the same cycle return the old value. The new value is visible from the next cycle.

**Arithmetic**
- `wptr` wraps modulo `DEPTH`. Wrap cannot be reached in practice, because `fill = DEPTH` forces RUN.
- `fill` saturates at `DEPTH`.

**Reset mid-operation**
- Asserting `reset` in any state returns all outputs and the memory to their reset values immediately. This is asynchronous and does not wait for a clock edge.
- Deassertion is synchronized internally by a 2-flop release chain. The first handshake can be accepted on the 2nd rising edge after `reset` goes high.

## Timing
- Write latency: data presented with a handshake at edge N is readable on `rd_data` after edge N.
- Last handshake, or `go`, at edge N:
  - `proc_rst` falls and `busy` rises after edge N.
  - `proc_rst` is low for exactly `RUN_CYCLES` cycles.
  - `done` rises after edge N+`RUN_CYCLES`, in the same cycle that `proc_rst` rises again.
- `clear` sampled at edge M in DONE: `done` falls and `wr_ready` rises after edge M.
- `proc_rst`, `busy`, `done` and `wr_ready` are decoded from registered state and are glitch-free.

## Configuration
- `MEM_LOADER_AUTOCLEAR_EN` defined:
  - Every transition DONE→LOAD also zeroes all `DEPTH` entries in that same cycle.
  - A subsequent partial load plus `go` therefore presents 0 for unwritten entries.
- Not defined: memory contents persist across runs; only `reset` zeroes them.

## Test plan
- **Full load:** after reset release, stream 3,7,1,F,0,2,9,4,8,6,5,C,A,B,D,E with `wr_valid` held high.
  - 16 handshakes; `busy` rises on the following cycle.
  - `proc_rst` is low for exactly 18 cycles, then `done` = 1.
  - The processor's `max` = F.
- **Backpressure:** in RUN, hold `wr_valid` = 1 with `wr_data` = F.
  - `wr_ready` stays 0; memory is unchanged; `fill` stays 16.
- **Early go:** write 5,9 then pulse `go`, with a third write (2) in the same cycle.
  - `fill` = 3 and `busy` = 1 on the next cycle.
  - `mem[2]` = 2; `rd_data` at `rd_addr` 3 equals its previous value. With `MEM_LOADER_AUTOCLEAR_EN` defined, that value is 0.
- **Clear:** in DONE pulse `clear`.
  - `done` = 0, `wr_ready` = 1, `fill` = 0 the next cycle.
  - `clear` pulsed during RUN has no effect.
- **Read-during-write:** write A to address 0 while `rd_addr` = 0.
  - `rd_data` shows the old value in that cycle and A in the next cycle.
- **Async reset mid-RUN:** drop `reset` between edges.
  - `proc_rst` = 1, `busy` = 0 and `rd_data` = 0 before the next edge.
  - After release, `wr_ready` = 1 and `fill` = 0.
